bmd_256_latency_calc: RTL
=========================

# bmd_256_latency_calc

Downstream consumer of the echo-latency timestamp BRAM. On each echo arrival from the RX engine it issues a BRAM read of the oldest stored start timestamp and waits out the 2-cycle read latency. It then subtracts that timestamp from the free-running latency counter and maintains last/min/max/sum/count statistics for VIO/register readout. It also tracks outstanding timestamps, so an echo with nothing stored is flagged instead of reading stale data.

## Interface
Parameters:
- CNT_WIDTH, 38, timestamp / latency counter width
- ADDR_WIDTH, 13, BRAM address width (8192 entries)
- COUNT_WIDTH, 16, sample counter width
- SAMPLE_LIMIT, 16'd8192, samples accumulated before entering DONE

Ports:
- clk  in  1  250 MHz user clock; sole clock
- rst_n  in  1  asynchronous, active-low reset
- latency_reset_signal  in  1  synchronous user clear (same signal drives BRAM rstb)
- latency_counter  in  CNT_WIDTH  free-running timestamp counter
- ts_wr_strobe  in  1  high for one cycle per timestamp written (bram_ena & bram_wea of the TX side)
- rx_echo_valid  in  1  one-cycle pulse per echo packet received
- bram_reb  out  1  BRAM port-B read enable
- bram_rd_addr  out  ADDR_WIDTH  BRAM port-B read address
- bram_rd_data  in  CNT_WIDTH  BRAM port-B data, valid 2 cycles after bram_reb
- lat_valid  out  1  one-cycle pulse: new sample on lat_last
- lat_last  out  CNT_WIDTH  latest latency (counter ticks)
- lat_min / lat_max  out  CNT_WIDTH  extrema over accepted samples
- lat_sum  out  CNT_WIDTH+COUNT_WIDTH  sum of accepted samples
- lat_count  out  COUNT_WIDTH  number of accepted samples
- stats_done  out  1  high in DONE state
- err_underflow  out  1  sticky: echo arrived with zero outstanding timestamps
- err_overflow  out  1  sticky: outstanding exceeded 2^ADDR_WIDTH

## Operation
- FSM: IDLE (no sample yet) → RUN on first lat_valid → DONE when lat_count reaches SAMPLE_LIMIT. DONE → IDLE only via clear or reset.
- Accept = rx_echo_valid & outstanding≠0 & state≠DONE & ~latency_reset_signal. bram_reb = accept (combinational); bram_rd_addr = rd_ptr register.
- rd_ptr increments on accept and wraps 2^ADDR_WIDTH−1 → 0.
- outstanding (ADDR_WIDTH+1 bits) +1 on ts_wr_strobe, −1 on accept; both in the same cycle leaves it unchanged. It saturates at 2^ADDR_WIDTH and sets err_overflow if a further strobe arrives.
- rx_echo_valid with outstanding=0 (state≠DONE): no read, set err_underflow.
- 3-stage pipe: latency_counter is captured at accept and carried alongside a valid bit to align with bram_rd_data.
- Latency = captured_counter − bram_rd_data, modulo 2^CNT_WIDTH, so counter wrap is handled.
- lat_sum is unsigned; its width cannot overflow within SAMPLE_LIMIT samples.
- latency_reset_signal (priority over everything): clears rd_ptr, outstanding, stats, errors and pipe valid bits; state → IDLE. In-flight samples are discarded.
- Echoes in DONE are ignored: no read, no error.
- Reset values: all outputs 0 except lat_min = all-ones.

## Timing
- Cycle T: accept, bram_reb=1, bram_rd_addr=rd_ptr, counter captured.
- T+2: bram_rd_data valid.
- T+3: lat_last, lat_min/lat_max/lat_sum/lat_count registered; lat_valid pulses.
- Sustains one echo per cycle back-to-back.
- stats_done asserts the cycle after the SAMPLE_LIMIT-th lat_valid.

## Structure
- Shared package holds CNT_WIDTH, ADDR_WIDTH, COUNT_WIDTH and the state encoding (IDLE/RUN/DONE), also used by the TX timestamp writer.
- One sub-module: bmd_256_latency_stats (min/max/sum/count accumulator with clear).

## Test plan
- Write timestamp 100 at addr 0, echo with latency_counter=350 → bram_reb at T, addr 0, lat_valid at T+3, lat_last=250, min=max=sum=250, count=1, state RUN.
- Timestamp 2^38−10, echo at counter 20 → lat_last=30 (wrap).
- 4 timestamps, 4 back-to-back echoes → addrs 0..3 on consecutive cycles, 4 consecutive lat_valid, correct min/max/sum.
- Echo with no writes → no bram_reb, err_underflow=1. rd_ptr at 8191 then accept → next addr 0.
- latency_reset_signal at T+1 after accept → no lat_valid, all stats cleared, lat_min=all-ones, state IDLE.
- SAMPLE_LIMIT=4 override: 5 echoes → count stops at 4, stats_done=1, 5th echo produces no bram_reb.

Source files
------------

// File: rtl/bmd_256_latency_calc_pkg.sv
// Shared definitions for the echo-latency path: counter/address widths and the
// statistics state encoding, common to the TX timestamp writer and the RX calculator.
package bmd_256_latency_calc_pkg;

  localparam int LAT_CNT_WIDTH   = 38;
  localparam int LAT_ADDR_WIDTH  = 13;
  localparam int LAT_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lat_state_e;

endpackage

// File: rtl/bmd_256_latency_stats.sv
// Latency statistics accumulator: last/min/max/sum/count with synchronous clear.
// Samples arriving once count has reached SAMPLE_LIMIT are dropped so count never exceeds it.
module bmd_256_latency_stats
  import bmd_256_latency_calc_pkg::*;
#(
  parameter int CNT_WIDTH   = LAT_CNT_WIDTH,
  parameter int COUNT_WIDTH = LAT_COUNT_WIDTH,
  parameter logic [COUNT_WIDTH-1:0] SAMPLE_LIMIT = 16'd8192
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         sample_valid,
  input  logic [CNT_WIDTH-1:0]         sample,
  output logic                         lat_valid,
  output logic [CNT_WIDTH-1:0]         lat_last,
  output logic [CNT_WIDTH-1:0]         lat_min,
  output logic [CNT_WIDTH-1:0]         lat_max,
  output logic [CNT_WIDTH+COUNT_WIDTH-1:0] lat_sum,
  output logic [COUNT_WIDTH-1:0]       lat_count
);

  localparam int SUM_WIDTH = CNT_WIDTH + COUNT_WIDTH;

  logic                   lat_valid_reg;
  logic [CNT_WIDTH-1:0]   lat_last_reg;
  logic [CNT_WIDTH-1:0]   lat_min_reg;
  logic [CNT_WIDTH-1:0]   lat_max_reg;
  logic [SUM_WIDTH-1:0]   lat_sum_reg;
  logic [COUNT_WIDTH-1:0] lat_count_reg;
  logic                   take;

  assign take = sample_valid && (lat_count_reg < SAMPLE_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_valid_reg <= 1'b0;
      lat_last_reg  <= '0;
      lat_min_reg   <= '1;
      lat_max_reg   <= '0;
      lat_sum_reg   <= '0;
      lat_count_reg <= '0;
    end else if (clr) begin
      lat_valid_reg <= 1'b0;
      lat_last_reg  <= '0;
      lat_min_reg   <= '1;
      lat_max_reg   <= '0;
      lat_sum_reg   <= '0;
      lat_count_reg <= '0;
    end else begin
      lat_valid_reg <= take;
      if (take) begin
        lat_last_reg  <= sample;
        if (sample < lat_min_reg) lat_min_reg <= sample;
        if (sample > lat_max_reg) lat_max_reg <= sample;
        lat_sum_reg   <= lat_sum_reg + {{COUNT_WIDTH{1'b0}}, sample};
        lat_count_reg <= lat_count_reg + COUNT_WIDTH'(1);
      end
    end
  end

  assign lat_valid = lat_valid_reg;
  assign lat_last  = lat_last_reg;
  assign lat_min   = lat_min_reg;
  assign lat_max   = lat_max_reg;
  assign lat_sum   = lat_sum_reg;
  assign lat_count = lat_count_reg;

endmodule

// File: rtl/bmd_256_latency_calc.sv
// Echo-latency calculator: pops the oldest start timestamp from BRAM on each echo,
// subtracts it from the free-running counter and feeds the statistics accumulator.
module bmd_256_latency_calc
  import bmd_256_latency_calc_pkg::*;
#(
  parameter int CNT_WIDTH   = LAT_CNT_WIDTH,
  parameter int ADDR_WIDTH  = LAT_ADDR_WIDTH,
  parameter int COUNT_WIDTH = LAT_COUNT_WIDTH,
  parameter logic [COUNT_WIDTH-1:0] SAMPLE_LIMIT = 16'd8192
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             latency_reset_signal,
  input  logic [CNT_WIDTH-1:0]             latency_counter,
  input  logic                             ts_wr_strobe,
  input  logic                             rx_echo_valid,
  output logic                             bram_reb,
  output logic [ADDR_WIDTH-1:0]            bram_rd_addr,
  input  logic [CNT_WIDTH-1:0]             bram_rd_data,
  output logic                             lat_valid,
  output logic [CNT_WIDTH-1:0]             lat_last,
  output logic [CNT_WIDTH-1:0]             lat_min,
  output logic [CNT_WIDTH-1:0]             lat_max,
  output logic [CNT_WIDTH+COUNT_WIDTH-1:0] lat_sum,
  output logic [COUNT_WIDTH-1:0]           lat_count,
  output logic                             stats_done,
  output logic                             err_underflow,
  output logic                             err_overflow
);

  localparam logic [ADDR_WIDTH:0] OUTSTANDING_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  lat_state_e            state_reg;
  logic                  stats_done_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   outstanding_reg;
  logic                  err_underflow_reg;
  logic                  err_overflow_reg;
  logic [1:0]            pipe_valid_reg;
  logic [CNT_WIDTH-1:0]  pipe_cnt_reg [2];

  logic                  echo_live;
  logic                  accept;
  logic                  underflow;
  logic [CNT_WIDTH-1:0]  sample;

  // An echo counts only outside DONE and when no clear is in progress.
  assign echo_live = rx_echo_valid && (state_reg != ST_DONE) && !latency_reset_signal;
  assign accept    = echo_live && (outstanding_reg != '0);
  assign underflow = echo_live && (outstanding_reg == '0);

  assign bram_reb     = accept;
  assign bram_rd_addr = rd_ptr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg        <= '0;
      outstanding_reg   <= '0;
      err_underflow_reg <= 1'b0;
      err_overflow_reg  <= 1'b0;
    end else if (latency_reset_signal) begin
      rd_ptr_reg        <= '0;
      outstanding_reg   <= '0;
      err_underflow_reg <= 1'b0;
      err_overflow_reg  <= 1'b0;
    end else begin
      if (accept) rd_ptr_reg <= rd_ptr_reg + ADDR_WIDTH'(1);
      if (ts_wr_strobe && !accept) begin
        if (outstanding_reg == OUTSTANDING_MAX) err_overflow_reg <= 1'b1;
        else outstanding_reg <= outstanding_reg + (ADDR_WIDTH+1)'(1);
      end else if (accept && !ts_wr_strobe) begin
        outstanding_reg <= outstanding_reg - (ADDR_WIDTH+1)'(1);
      end
      if (underflow) err_underflow_reg <= 1'b1;
    end
  end

  // Counter snapshot travels two stages to line up with the 2-cycle BRAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_reg  <= '0;
      pipe_cnt_reg[0] <= '0;
      pipe_cnt_reg[1] <= '0;
    end else if (latency_reset_signal) begin
      pipe_valid_reg  <= '0;
    end else begin
      pipe_valid_reg  <= {pipe_valid_reg[0], accept};
      pipe_cnt_reg[0] <= latency_counter;
      pipe_cnt_reg[1] <= pipe_cnt_reg[0];
    end
  end

  // Modular difference handles counter wrap between write and echo.
  assign sample = pipe_cnt_reg[1] - bram_rd_data;

  bmd_256_latency_stats #(
    .CNT_WIDTH    (CNT_WIDTH),
    .COUNT_WIDTH  (COUNT_WIDTH),
    .SAMPLE_LIMIT (SAMPLE_LIMIT)
  ) u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (latency_reset_signal),
    .sample_valid (pipe_valid_reg[1]),
    .sample       (sample),
    .lat_valid    (lat_valid),
    .lat_last     (lat_last),
    .lat_min      (lat_min),
    .lat_max      (lat_max),
    .lat_sum      (lat_sum),
    .lat_count    (lat_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      stats_done_reg <= 1'b0;
    end else if (latency_reset_signal) begin
      state_reg      <= ST_IDLE;
      stats_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_RUN: begin
          if (lat_valid) begin
            if (lat_count >= SAMPLE_LIMIT) begin
              state_reg      <= ST_DONE;
              stats_done_reg <= 1'b1;
            end else begin
              state_reg      <= ST_RUN;
            end
          end
        end
        ST_DONE: state_reg <= ST_DONE;
        default: begin
          state_reg      <= ST_IDLE;
          stats_done_reg <= 1'b0;
        end
      endcase
    end
  end

  assign stats_done    = stats_done_reg;
  assign err_underflow = err_underflow_reg;
  assign err_overflow  = err_overflow_reg;

endmodule
